// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host arbiter: default widths and FSM encoding.
package sdram_pkg;

  localparam int SDRAM_ADDR_W  = 24;
  localparam int SDRAM_DATA_W  = 16;
  localparam int SDRAM_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Maps the owning port number to its one-hot response/ready lane.
  function automatic logic [1:0] onehot_port(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_host_arbiter_rr.sv
// Two-way round-robin grant: a tie goes to the port not granted last time.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Combinational grant selection
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Arbitrates two host requesters onto a single SDRAM controller command port,
// one command outstanding at a time, with busy-timeout and read-data checking.
module sdram_host_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W  = SDRAM_ADDR_W,
  parameter int DATA_W  = SDRAM_DATA_W,
  parameter int TIMEOUT = SDRAM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rsp_valid,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  output logic              ctl_wr_enable,
  output logic              ctl_rd_enable,
  input  logic              ctl_busy,
  input  logic [DATA_W-1:0] ctl_rd_data,
  input  logic              ctl_rd_ready
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_t        state_r, state_s;
  logic              owner_r, owner_s;
  logic              we_r, we_s;
  logic              last_r, last_s;
  logic              rd_seen_r, rd_seen_s;
  logic [DATA_W-1:0] rd_buf_r, rd_buf_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [1:0]        rdy_r, rdy_s;
  logic [1:0]        rsp_r, rsp_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              err_r, err_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              wr_en_r, wr_en_s;
  logic              rd_en_r, rd_en_s;
  logic [1:0]        gnt_s;

  rr_arbiter2 u_rr (
    .req  ({p1_valid, p0_valid}),
    .last (last_r),
    .gnt  (gnt_s)
  );

  assign p0_ready      = rdy_r[0];
  assign p1_ready      = rdy_r[1];
  assign p0_rsp_valid  = rsp_r[0];
  assign p1_rsp_valid  = rsp_r[1];
  assign rsp_rdata     = rdata_r;
  assign rsp_err       = err_r;
  assign ctl_addr      = addr_r;
  assign ctl_wdata     = wdata_r;
  assign ctl_wr_enable = wr_en_r;
  assign ctl_rd_enable = rd_en_r;

  // Next-state and next-output computation
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    we_s      = we_r;
    last_s    = last_r;
    rd_seen_s = rd_seen_r;
    rd_buf_s  = rd_buf_r;
    cnt_s     = cnt_r;
    rdy_s     = 2'b00;
    rsp_s     = 2'b00;
    rdata_s   = rdata_r;
    err_s     = err_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    wr_en_s   = wr_en_r;
    rd_en_s   = rd_en_r;
    case (state_r)
      ST_IDLE: begin
        if ((gnt_s != 2'b00) && !ctl_busy) begin
          owner_s   = gnt_s[1];
          last_s    = gnt_s[1];
          we_s      = gnt_s[1] ? p1_we : p0_we;
          addr_s    = gnt_s[1] ? p1_addr : p0_addr;
          wdata_s   = gnt_s[1] ? p1_wdata : p0_wdata;
          wr_en_s   = we_s;
          rd_en_s   = !we_s;
          rdy_s     = gnt_s;
          cnt_s     = '0;
          rd_seen_s = 1'b0;
          rd_buf_s  = '0;
          state_s   = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (ctl_busy) begin
          wr_en_s = 1'b0;
          rd_en_s = 1'b0;
          state_s = ST_RUN;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          wr_en_s = 1'b0;
          rd_en_s = 1'b0;
          rsp_s   = onehot_port(owner_r);
          rdata_s = '0;
          err_s   = 1'b1;
          state_s = ST_RESP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!we_r && ctl_rd_ready) begin
          rd_seen_s = 1'b1;
          rd_buf_s  = ctl_rd_data;
        end else begin
          rd_seen_s = rd_seen_r;
        end
        // Read data arriving in the same cycle busy falls still counts.
        if (!ctl_busy) begin
          rsp_s   = onehot_port(owner_r);
          state_s = ST_RESP;
          if (we_r) begin
            rdata_s = '0;
            err_s   = 1'b0;
          end else if (ctl_rd_ready) begin
            rdata_s = ctl_rd_data;
            err_s   = 1'b0;
          end else if (rd_seen_r) begin
            rdata_s = rd_buf_r;
            err_s   = 1'b0;
          end else begin
            rdata_s = '0;
            err_s   = 1'b1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      owner_r   <= 1'b0;
      we_r      <= 1'b0;
      last_r    <= 1'b1;
      rd_seen_r <= 1'b0;
      rd_buf_r  <= '0;
      cnt_r     <= '0;
      rdy_r     <= 2'b00;
      rsp_r     <= 2'b00;
      rdata_r   <= '0;
      err_r     <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      we_r      <= we_s;
      last_r    <= last_s;
      rd_seen_r <= rd_seen_s;
      rd_buf_r  <= rd_buf_s;
      cnt_r     <= cnt_s;
      rdy_r     <= rdy_s;
      rsp_r     <= rsp_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      wr_en_r   <= wr_en_s;
      rd_en_r   <= rd_en_s;
    end
  end

endmodule
